// File: rtl/data_mem_responder.sv
// Data-memory responder: services byte/half/word loads and stores from an
// internal word-organised RAM and returns data plus a response code after a
// fixed number of cycles. After reset the RAM is swept to zero before any
// request is accepted.
module data_mem_responder #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned COUNT_W     = 2,
    parameter int unsigned CODE_W      = 2,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [ADDR_W-1:0]  i_mem_req_addr,
    input  logic [WORD_W-1:0]  i_mem_req_wr_data,
    input  logic               i_mem_req_wr_en,
    input  logic [COUNT_W-1:0] i_mem_req_count,
    output logic [WORD_W-1:0]  o_mem_res_rd_data,
    output logic [CODE_W-1:0]  o_mem_res_code,
    output logic               o_init_done
);

    // Byte-address width covering the whole RAM, and the word-index width.
    localparam int unsigned BYTE_AW = $clog2(4 * DEPTH_WORDS);
    localparam int unsigned IDX_W   = BYTE_AW - 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

    typedef enum logic [CODE_W-1:0] {
        RES_NONE = 0,
        RES_OK   = 1,
        RES_ERR  = 2,
        RES_BUSY = 3
    } res_code_e;

    typedef enum logic [COUNT_W-1:0] {
        SZ_NONE = 0,
        SZ_BYTE = 1,
        SZ_HALF = 2,
        SZ_WORD = 3
    } req_size_e;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_e;

    // Storage and control state
    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
    state_e            state_q;
    logic [IDX_W-1:0]  init_ptr_q;
    logic              init_done_q;

    // Response pipeline; the last stage drives the outputs
    res_code_e         code_q [LATENCY];
    logic [WORD_W-1:0] data_q [LATENCY];

    // Request decode
    req_size_e         req_size;
    logic              req_valid;
    logic              misaligned;
    logic              out_of_range;
    logic [IDX_W-1:0]  word_idx;
    logic [1:0]        lane;
    logic [4:0]        lane_shift;
    logic [3:0]        lane_mask;
    logic [WORD_W-1:0] rd_word;
    logic [WORD_W-1:0] load_data;
    logic [WORD_W-1:0] wr_shifted;
    logic [WORD_W-1:0] store_word;
    logic              store_en;
    res_code_e         resp_code_d;
    logic [WORD_W-1:0] resp_data_d;

    // Decode the incoming request: size, address checks, lane selection.
    always_comb begin
        req_size     = req_size_e'(i_mem_req_count);
        req_valid    = (req_size != SZ_NONE);
        lane         = i_mem_req_addr[1:0];
        lane_shift   = {lane, 3'b000};
        word_idx     = i_mem_req_addr[BYTE_AW-1:2];
        misaligned   = ((req_size == SZ_HALF) && i_mem_req_addr[0]) ||
                       ((req_size == SZ_WORD) && (lane != 2'b00));
        out_of_range = ((i_mem_req_addr >> BYTE_AW) != '0);
        case (req_size)
            SZ_BYTE: lane_mask = 4'b0001 << lane;
            SZ_HALF: lane_mask = 4'b0011 << lane;
            SZ_WORD: lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    end

    // Asynchronous RAM read plus load extraction and store lane merge.
    // Reading the array directly makes a store at one edge visible to a
    // load sampled at the very next edge.
    always_comb begin
        rd_word    = mem_q[word_idx];
        wr_shifted = i_mem_req_wr_data << lane_shift;
        store_word = rd_word;
        for (int unsigned b = 0; b < 4; b++) begin
            if (lane_mask[b]) begin
                store_word[8*b +: 8] = wr_shifted[8*b +: 8];
            end
        end
        case (req_size)
            SZ_BYTE: load_data = (rd_word >> lane_shift) & 32'h0000_00FF;
            SZ_HALF: load_data = (rd_word >> lane_shift) & 32'h0000_FFFF;
            SZ_WORD: load_data = rd_word;
            default: load_data = '0;
        endcase
    end

    // Choose the response for this cycle's request and whether it stores.
    always_comb begin
        resp_code_d = RES_NONE;
        resp_data_d = '0;
        store_en    = 1'b0;
        if (req_valid) begin
            if (state_q == ST_INIT) begin
                resp_code_d = RES_BUSY;
            end else if (misaligned || out_of_range) begin
                resp_code_d = RES_ERR;
            end else begin
                resp_code_d = RES_OK;
                if (i_mem_req_wr_en) begin
                    store_en = 1'b1;
                end else begin
                    resp_data_d = load_data;
                end
            end
        end
    end

    // RAM write port: clear sweep during INIT, otherwise accepted stores.
    // The array is deliberately not reset; INIT zeroes it after every clr.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            mem_q[init_ptr_q] <= '0;
        end else if (store_en) begin
            mem_q[word_idx] <= store_word;
        end
    end

    // Init/ready FSM with the clear pointer and registered done flag.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= ST_INIT;
            init_ptr_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    init_ptr_q <= init_ptr_q + 1'b1;
                    if (init_ptr_q == LAST_IDX) begin
                        state_q     <= ST_READY;
                        init_done_q <= 1'b1;
                    end
                end
                ST_READY: begin
                    state_q <= ST_READY;
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    // Response delay line; clr drops everything in flight.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int unsigned k = 0; k < LATENCY; k++) begin
                code_q[k] <= RES_NONE;
                data_q[k] <= '0;
            end
        end else begin
            code_q[0] <= resp_code_d;
            data_q[0] <= resp_data_d;
            for (int unsigned k = 1; k < LATENCY; k++) begin
                code_q[k] <= code_q[k-1];
                data_q[k] <= data_q[k-1];
            end
        end
    end

    assign o_mem_res_code    = code_q[LATENCY-1];
    assign o_mem_res_rd_data = data_q[LATENCY-1];
    assign o_init_done       = init_done_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: two instances (LATENCY 1 and 3) share
// one request stream and are checked against a byte-array reference model.
module tb_data_mem_responder;

    localparam int DEPTH  = 16;
    localparam int NBYTES = 4 * DEPTH;
    localparam int HMAX   = 2048;

    localparam logic [1:0] C_NONE = 2'd0;
    localparam logic [1:0] C_OK   = 2'd1;
    localparam logic [1:0] C_ERR  = 2'd2;
    localparam logic [1:0] C_BUSY = 2'd3;

    logic        clk;
    logic        clr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [1:0]  cnt;

    logic [31:0] rd1, rd3;
    logic [1:0]  code1, code3;
    logic        done1, done3;

    int checks;
    int errors;

    // Reference model state
    byte unsigned mref [NBYTES];
    int           init_edges;
    int           e;
    logic [1:0]   hcode [HMAX];
    logic [31:0]  hdata [HMAX];

    data_mem_responder #(
        .ADDR_W(32), .WORD_W(32), .COUNT_W(2), .CODE_W(2),
        .DEPTH_WORDS(DEPTH), .LATENCY(1)
    ) u_dut1 (
        .clk(clk), .clr(clr),
        .i_mem_req_addr(addr), .i_mem_req_wr_data(wdata),
        .i_mem_req_wr_en(we), .i_mem_req_count(cnt),
        .o_mem_res_rd_data(rd1), .o_mem_res_code(code1),
        .o_init_done(done1)
    );

    data_mem_responder #(
        .ADDR_W(32), .WORD_W(32), .COUNT_W(2), .CODE_W(2),
        .DEPTH_WORDS(DEPTH), .LATENCY(3)
    ) u_dut3 (
        .clk(clk), .clr(clr),
        .i_mem_req_addr(addr), .i_mem_req_wr_data(wdata),
        .i_mem_req_wr_en(we), .i_mem_req_count(cnt),
        .o_mem_res_rd_data(rd3), .o_mem_res_code(code3),
        .o_init_done(done3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Model of one clock edge: the response the request earns, then its effects.
    task automatic model_edge(input logic [1:0] c, input logic w, input logic [31:0] a,
                              input logic [31:0] d, output logic [1:0] rc, output logic [31:0] rv);
        int nb;
        rc = C_NONE;
        rv = 32'h0;
        nb = (c == 2'd3) ? 4 : int'(c);
        if (c != 2'd0) begin
            if (init_edges < DEPTH) begin
                rc = C_BUSY;
            end else if ((c == 2'd2 && (a % 2) != 0) || (c == 2'd3 && (a % 4) != 0) ||
                         (a >= 32'(NBYTES))) begin
                rc = C_ERR;
            end else begin
                rc = C_OK;
                for (int i = 0; i < nb; i++) begin
                    if (w) mref[a + 32'(i)] = 8'((d >> (8 * i)) & 32'hFF);
                    else   rv = rv | (32'(mref[a + 32'(i)]) << (8 * i));
                end
            end
        end
        if (init_edges < DEPTH) begin
            init_edges++;
            if (init_edges == DEPTH) begin
                for (int i = 0; i < NBYTES; i++) mref[i] = 8'h00;
            end
        end
    endtask

    task automatic check_outputs();
        logic [31:0] exp_done;
        exp_done = (init_edges >= DEPTH) ? 32'd1 : 32'd0;
        chk("code_L1", {30'b0, code1}, {30'b0, hcode[e]});
        chk("data_L1", rd1, hdata[e]);
        chk("done_L1", {31'b0, done1}, exp_done);
        chk("code_L3", {30'b0, code3}, {30'b0, hcode[e-2]});
        chk("data_L3", rd3, hdata[e-2]);
        chk("done_L3", {31'b0, done3}, exp_done);
    endtask

    task automatic step(input logic [1:0] c, input logic w, input logic [31:0] a, input logic [31:0] d);
        logic [1:0]  rc;
        logic [31:0] rv;
        cnt   = c;
        we    = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        model_edge(c, w, a, d, rc, rv);
        e++;
        hcode[e] = rc;
        hdata[e] = rv;
        #1;
        check_outputs();
    endtask

    // Assert clr right after an edge; responses in flight are discarded.
    task automatic pulse_reset(input int cycles);
        cnt = 2'd0;
        we  = 1'b0;
        clr = 1'b1;
        #1;
        chk("rst_code_L1", {30'b0, code1}, {30'b0, C_NONE});
        chk("rst_code_L3", {30'b0, code3}, {30'b0, C_NONE});
        chk("rst_data_L3", rd3, 32'h0);
        chk("rst_done_L3", {31'b0, done3}, 32'd0);
        hcode[e] = C_NONE;   hdata[e] = 32'h0;
        hcode[e-1] = C_NONE; hdata[e-1] = 32'h0;
        repeat (cycles) begin
            @(posedge clk);
            e++;
            hcode[e] = C_NONE;
            hdata[e] = 32'h0;
        end
        #1;
        chk("rst_done_L1", {31'b0, done1}, 32'd0);
        clr = 1'b0;
        init_edges = 0;
    endtask

    initial begin
        logic [1:0]  rc;
        logic        rw;
        logic [31:0] ra, rd;
        checks = 0;
        errors = 0;
        e = 2;
        init_edges = 0;
        for (int i = 0; i < HMAX; i++) begin
            hcode[i] = C_NONE;
            hdata[i] = 32'h0;
        end
        for (int i = 0; i < NBYTES; i++) mref[i] = 8'h00;
        clr = 1'b1; cnt = 2'd0; we = 1'b0; addr = 32'h0; wdata = 32'h0;

        pulse_reset(3);

        // Clear sweep; one load while busy
        for (int i = 1; i <= DEPTH; i++) begin
            if (i == 5) step(2'd3, 1'b0, 32'h3C, 32'h0);
            else        step(2'd0, 1'b0, 32'h0, 32'h0);
        end
        chk("done_after_init", {31'b0, done1}, 32'd1);
        step(2'd3, 1'b0, 32'h3C, 32'h0);

        // Word store then byte/half/word loads
        step(2'd3, 1'b1, 32'h10, 32'hDEADBEEF);
        step(2'd3, 1'b0, 32'h10, 32'h0);
        chk("ld_word_dead", rd1, 32'hDEADBEEF);
        step(2'd1, 1'b0, 32'h13, 32'h0);
        step(2'd2, 1'b0, 32'h12, 32'h0);

        // Byte store merges into the existing word
        step(2'd1, 1'b1, 32'h11, 32'hFFFFFF55);
        step(2'd3, 1'b0, 32'h10, 32'h0);
        chk("ld_word_merge", rd1, 32'hDEAD55EF);

        // Error cases
        step(2'd2, 1'b0, 32'h11, 32'h0);
        step(2'd3, 1'b1, 32'h12, 32'h12345678);
        step(2'd3, 1'b0, 32'h10, 32'h0);
        step(2'd3, 1'b0, 32'h40, 32'h0);
        step(2'd1, 1'b1, 32'h47, 32'hAA);

        // Back-to-back loads with idle gaps
        step(2'd3, 1'b1, 32'h0, 32'h11223344);
        step(2'd3, 1'b1, 32'h4, 32'h55667788);
        step(2'd3, 1'b1, 32'h8, 32'h99AABBCC);
        step(2'd0, 1'b0, 32'h0, 32'h0);
        step(2'd3, 1'b0, 32'h0, 32'h0);
        step(2'd3, 1'b0, 32'h4, 32'h0);
        step(2'd3, 1'b0, 32'h8, 32'h0);
        repeat (3) step(2'd0, 1'b0, 32'h0, 32'h0);

        // Randomised traffic
        for (int n = 0; n < 300; n++) begin
            rc = 2'($urandom_range(0, 3));
            rw = 1'($urandom_range(0, 1));
            ra = 32'($urandom_range(0, NBYTES + 7));
            rd = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (rc == 2'd2) ra = ra & ~32'h1;
                if (rc == 2'd3) ra = ra & ~32'h3;
            end
            step(rc, rw, ra, rd);
        end

        // Reset with two responses in flight on the LATENCY=3 instance
        step(2'd3, 1'b0, 32'h0, 32'h0);
        step(2'd3, 1'b0, 32'h4, 32'h0);
        pulse_reset(1);
        for (int i = 1; i <= DEPTH; i++) begin
            if (i == 3) step(2'd3, 1'b1, 32'h8, 32'hCAFEF00D);
            else        step(2'd0, 1'b0, 32'h0, 32'h0);
        end
        step(2'd3, 1'b0, 32'h8, 32'h0);
        step(2'd3, 1'b0, 32'h0, 32'h0);
        repeat (3) step(2'd0, 1'b0, 32'h0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
